// File: rtl/aer_key_mapper.sv
// aer_key_mapper: maps AER event addresses to SpiNNaker multicast keys, with mode switching only once the output has drained.
module aer_key_mapper #(
  parameter int          MODE_BITS     = 4,
  parameter logic [15:0] DEF_CHIP_ADDR = 16'h0200,
  parameter logic [15:0] ALT_CHIP_ADDR = 16'hFEFF,
  parameter int          CNT_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MODE_BITS-1:0] mode,
  input  logic [15:0]          in_data,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [31:0]          out_key,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [MODE_BITS-1:0] mode_active,
  input  logic                 cnt_clr,
  output logic [CNT_BITS-1:0]  evt_cnt,
  output logic [CNT_BITS-1:0]  drop_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  localparam logic [MODE_BITS-1:0] M4 = MODE_BITS'(4);
  localparam logic [MODE_BITS-1:0] M5 = MODE_BITS'(5);
  localparam logic [MODE_BITS-1:0] M6 = MODE_BITS'(6);
  localparam logic [MODE_BITS-1:0] M12 = MODE_BITS'(12);
  state_t state, state_n;
  logic [MODE_BITS-1:0] mode_q, sub;
  logic [1:0] s;
  logic [15:0] key_lo;
  logic [31:0] key;
  logic valid_mode, in_xfer, out_xfer;
  always_comb begin
    valid_mode = mode_q < M12;
    sub = mode_q >= M6 ? mode_q - M6 : mode_q;
    s = sub[1:0];
    key_lo = sub == M4 ? {6'b0, in_data[9:0]} :
             sub == M5 ? in_data :
             {1'b0, in_data[14:8] >> s, in_data[7:1] >> s, in_data[0]};
    key = {mode_q >= M6 ? ALT_CHIP_ADDR : DEF_CHIP_ADDR, key_lo};
    in_rdy = state == RUN && mode == mode_q && (!out_vld || out_rdy);
    in_xfer = in_vld && in_rdy;
    out_xfer = out_vld && out_rdy;
    state_n = state == RUN ? (mode != mode_q ? DRAIN : RUN) :
              state == DRAIN ? (out_vld ? DRAIN : LOAD) : RUN;
  end
  assign mode_active = mode_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      mode_q <= '0;
      out_vld <= 1'b0;
      out_key <= '0;
      evt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD) mode_q <= mode;
      if (in_xfer && valid_mode) begin
        out_vld <= 1'b1;
        out_key <= key;
      end else if (out_xfer) out_vld <= 1'b0;
      evt_cnt <= cnt_clr ? '0 : (out_xfer && !(&evt_cnt)) ? evt_cnt + 1'b1 : evt_cnt;
      drop_cnt <= cnt_clr ? '0 : (in_xfer && !valid_mode && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule
